// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet transmit path.
// The CRC step is kept here so the receive checker can reuse it.
package eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG,
    ST_DRAIN
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int unsigned PREAMBLE_LEN  = 7;
  localparam int unsigned FCS_LEN       = 4;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  localparam logic [10:0] BYTE_CNT_MAX  = 11'h7FF;

  // One byte of the reflected CRC32, LSB of the byte first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [10:0] sat_inc(input logic [10:0] c);
    return (c == BYTE_CNT_MAX) ? c : c + 11'd1;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide CRC32 accumulator; holds the raw (uninverted) remainder.
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  d,
  output logic [31:0] crc
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_next(crc, d);
    end
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload, zero pad, FCS and inter-frame gap.
// State names the byte currently on gmii_txd; every output is registered from next-state logic.
module gmii_tx_framer
  import eth_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned MIN_PAYLOAD = 60,
  parameter bit          PAD_EN      = 1'b1
) (
  input  logic       gmii_tx_clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam logic [7:0]  PRE_LAST     = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  FCS_LAST     = 8'(FCS_LEN - 1);
  localparam logic [7:0]  FCS_PRE_LAST = 8'(FCS_LEN - 2);
  localparam logic [7:0]  IFG_LAST     = 8'(IFG_CYCLES - 2);
  localparam logic [10:0] MIN_CNT      = 11'(MIN_PAYLOAD);
  // The single IDLE cycle before the next preamble is the last gap cycle.
  localparam bit          HAS_IFG      = (IFG_CYCLES > 1);

  tx_state_t   state, state_nxt;
  logic [10:0] byte_cnt, byte_cnt_nxt;
  logic [7:0]  cyc_cnt, cyc_cnt_nxt;
  logic        last_seen, last_nxt;
  logic        ready_nxt, txen_nxt, txer_nxt, done_nxt, abort_nxt;
  logic [7:0]  txd_nxt;
  logic        crc_clear, crc_en;
  logic [7:0]  crc_d;
  logic [31:0] crc, fcs_word;

  crc32_d8 u_crc (
    .clk   (gmii_tx_clk),
    .reset (reset),
    .clear (crc_clear),
    .en    (crc_en),
    .d     (crc_d),
    .crc   (crc)
  );

  // FCS byte that follows the one indexed by cyc_cnt, LSB byte first.
  assign fcs_word = ~crc >> {cyc_cnt[1:0] + 2'd1, 3'b000};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    cyc_cnt_nxt  = cyc_cnt;
    last_nxt     = last_seen;
    ready_nxt    = s_ready;
    txd_nxt      = 8'h00;
    txen_nxt     = 1'b0;
    txer_nxt     = 1'b0;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    crc_clear    = 1'b0;
    crc_en       = 1'b0;
    crc_d        = 8'h00;

    case (state)
      ST_IDLE: if (s_valid) begin
        state_nxt    = ST_PRE;
        cyc_cnt_nxt  = '0;
        byte_cnt_nxt = '0;
        last_nxt     = 1'b0;
        crc_clear    = 1'b1;
        txen_nxt     = 1'b1;
        txd_nxt      = PREAMBLE_BYTE;
      end
      ST_PRE: begin
        txen_nxt = 1'b1;
        if (cyc_cnt == PRE_LAST) begin
          state_nxt = ST_SFD;
          txd_nxt   = SFD_BYTE;
          ready_nxt = 1'b1;
        end else begin
          cyc_cnt_nxt = cyc_cnt + 8'd1;
          txd_nxt     = PREAMBLE_BYTE;
        end
      end
      ST_SFD, ST_DATA: begin
        txen_nxt = 1'b1;
        if (last_seen) begin
          if (PAD_EN && (byte_cnt < MIN_CNT)) begin
            state_nxt    = ST_PAD;
            byte_cnt_nxt = sat_inc(byte_cnt);
            crc_en       = 1'b1;
          end else begin
            state_nxt   = ST_FCS;
            cyc_cnt_nxt = '0;
            txd_nxt     = ~crc[7:0];
          end
        end else if (s_valid) begin
          state_nxt    = ST_DATA;
          txd_nxt      = s_data;
          crc_en       = 1'b1;
          crc_d        = s_data;
          byte_cnt_nxt = sat_inc(byte_cnt);
          if (s_last) begin
            last_nxt  = 1'b1;
            ready_nxt = 1'b0;
          end
        end else begin
          // Underrun: flag one errored byte, then swallow the rest of the frame.
          state_nxt = ST_DRAIN;
          txer_nxt  = 1'b1;
          abort_nxt = 1'b1;
        end
      end
      ST_PAD: begin
        txen_nxt = 1'b1;
        if (byte_cnt < MIN_CNT) begin
          byte_cnt_nxt = sat_inc(byte_cnt);
          crc_en       = 1'b1;
        end else begin
          state_nxt   = ST_FCS;
          cyc_cnt_nxt = '0;
          txd_nxt     = ~crc[7:0];
        end
      end
      ST_FCS: begin
        if (cyc_cnt == FCS_LAST) begin
          state_nxt   = HAS_IFG ? ST_IFG : ST_IDLE;
          cyc_cnt_nxt = '0;
        end else begin
          txen_nxt    = 1'b1;
          txd_nxt     = fcs_word[7:0];
          done_nxt    = (cyc_cnt == FCS_PRE_LAST);
          cyc_cnt_nxt = cyc_cnt + 8'd1;
        end
      end
      ST_IFG: begin
        if (cyc_cnt == IFG_LAST) state_nxt = ST_IDLE;
        else                     cyc_cnt_nxt = cyc_cnt + 8'd1;
      end
      ST_DRAIN: if (s_valid && s_last) begin
        state_nxt   = HAS_IFG ? ST_IFG : ST_IDLE;
        cyc_cnt_nxt = '0;
        ready_nxt   = 1'b0;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      cyc_cnt   <= '0;
      last_seen <= 1'b0;
      s_ready   <= 1'b0;
      gmii_txd  <= 8'h00;
      gmii_txen <= 1'b0;
      gmii_txer <= 1'b0;
      tx_done   <= 1'b0;
      tx_abort  <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      cyc_cnt   <= cyc_cnt_nxt;
      last_seen <= last_nxt;
      s_ready   <= ready_nxt;
      gmii_txd  <= txd_nxt;
      gmii_txen <= txen_nxt;
      gmii_txer <= txer_nxt;
      tx_done   <= done_nxt;
      tx_abort  <= abort_nxt;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: one unpadded instance and one padded instance
// share the stimulus; sel_nopad chooses which one receives s_valid and is observed.
module tb_gmii_tx_framer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid, s_last, sel_nopad;

  logic       rdy_a, txen_a, txer_a, done_a, abort_a;
  logic       rdy_b, txen_b, txer_b, done_b, abort_b;
  logic [7:0] txd_a, txd_b;
  logic       s_valid_a, s_valid_b;
  logic       rdy, txen, txer, done, abort;
  logic [7:0] txd;

  assign s_valid_a = s_valid & sel_nopad;
  assign s_valid_b = s_valid & ~sel_nopad;
  assign rdy   = sel_nopad ? rdy_a   : rdy_b;
  assign txen  = sel_nopad ? txen_a  : txen_b;
  assign txer  = sel_nopad ? txer_a  : txer_b;
  assign done  = sel_nopad ? done_a  : done_b;
  assign abort = sel_nopad ? abort_a : abort_b;
  assign txd   = sel_nopad ? txd_a   : txd_b;

  gmii_tx_framer #(.IFG_CYCLES(12), .MIN_PAYLOAD(60), .PAD_EN(1'b0)) u_nopad (
    .gmii_tx_clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_a), .s_last(s_last),
    .s_ready(rdy_a), .gmii_txd(txd_a), .gmii_txen(txen_a), .gmii_txer(txer_a),
    .tx_done(done_a), .tx_abort(abort_a));

  gmii_tx_framer #(.IFG_CYCLES(12), .MIN_PAYLOAD(60), .PAD_EN(1'b1)) u_pad (
    .gmii_tx_clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid_b), .s_last(s_last),
    .s_ready(rdy_b), .gmii_txd(txd_b), .gmii_txen(txen_b), .gmii_txer(txer_b),
    .tx_done(done_b), .tx_abort(abort_b));

  always #4 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  pay [0:2047];
  logic [7:0]  wire_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] ref_fcs;
  int txen_cycles, txen_rises, done_cnt, done_pos, abort_cnt, txer_cnt, first_txen;
  bit timed_out;
  logic rst_txen, rst_txer, rst_rdy;
  int gap, rdy_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wbyte(input int i);
    if (i >= 0 && i < wire_q.size()) return wire_q[i];
    return 8'hxx;
  endfunction

  task automatic fill_pay(input int len, input int seed);
    for (int i = 0; i < len; i++) pay[i] = 8'(i * 13 + seed);
  endtask

  // Expected wire image; reference CRC is computed bit-serially.
  task automatic build_expected(input int len, input bit pad_en);
    logic [7:0] body[$];
    logic [31:0] c;
    logic fb;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < len; i++) body.push_back(pay[i]);
    if (pad_en) while (body.size() < 60) body.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (body[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body[k][b];
        c  = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB8_8320;
      end
      exp_q.push_back(body[k]);
    end
    ref_fcs = ~c;
    for (int i = 0; i < 4; i++) exp_q.push_back(ref_fcs[8*i +: 8]);
  endtask

  // Streams pay[0..len-1], recording every txen byte until the frame is over.
  task automatic drive_frame(input int len, input int stall_after, input bit hold, input int reset_at);
    int idx = 0;
    int cyc = 0;
    bit pend = 1'b0;
    bit stalled = 1'b0;
    bit finished = 1'b0;
    logic prev_en;
    wire_q.delete();
    txen_cycles = 0; txen_rises = 0; done_cnt = 0; done_pos = -1;
    abort_cnt = 0; txer_cnt = 0; first_txen = -1; timed_out = 1'b0;
    prev_en = txen;
    while (!finished) begin
      @(negedge clk);
      if (pend) idx++;
      if (txen) begin
        wire_q.push_back(txd);
        txen_cycles++;
        if (!prev_en) txen_rises++;
        if (first_txen < 0) first_txen = cyc;
      end
      prev_en = txen;
      if (txer)  txer_cnt++;
      if (done)  begin done_cnt++; done_pos = wire_q.size(); end
      if (abort) abort_cnt++;
      if (reset_at >= 0 && idx == reset_at) begin
        #2 reset = 1'b1;
        #1;
        rst_txen = txen; rst_txer = txer; rst_rdy = rdy;
        s_valid = 1'b0; s_last = 1'b0;
        finished = 1'b1;
      end else begin
        if (idx == len && !txen) finished = 1'b1;
        if (idx < len && !(idx == stall_after && !stalled)) begin
          s_valid = 1'b1; s_data = pay[idx]; s_last = (idx == len - 1);
        end else if (idx < len) begin
          s_valid = 1'b0; s_last = 1'b0; stalled = 1'b1;
        end else begin
          s_valid = hold; s_data = pay[0]; s_last = 1'b0;
        end
        pend = s_valid && rdy;
        cyc++;
        if (cyc >= 4000 && !finished) begin
          timed_out = 1'b1; finished = 1'b1; s_valid = 1'b0;
        end
      end
    end
  endtask

  // Counts txen-low cycles from the current (already idle) cycle to the next preamble.
  task automatic measure_gap(output int g, output int bad);
    g = 1;
    bad = rdy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txen) break;
      g++;
      if (rdy) bad++;
    end
  endtask

  task automatic cmp_tail(input string tag, input int n);
    int bad = 0;
    if (wire_q.size() < n || exp_q.size() < n) bad = n;
    else for (int i = 1; i <= n; i++)
      if (wire_q[wire_q.size() - i] !== exp_q[exp_q.size() - i]) bad++;
    chk({tag, " byte errors"}, 32'(bad), 32'd0);
  endtask

  initial begin
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; sel_nopad = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txd",   32'(txd),   32'h00);
    chk("reset txen",  32'(txen),  32'd0);
    chk("reset txer",  32'(txer),  32'd0);
    chk("reset ready", 32'(rdy),   32'd0);
    chk("reset done",  32'(done),  32'd0);
    chk("reset abort", 32'(abort), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Unpadded "123456789": known check value CBF43926 sent LSB first.
    sel_nopad = 1'b1;
    for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
    build_expected(9, 1'b0);
    drive_frame(9, -1, 1'b0, -1);
    chk("ascii timeout", 32'(timed_out), 32'd0);
    chk("ascii latency", 32'(first_txen), 32'd1);
    chk("ascii size", 32'(wire_q.size()), 32'd21);
    cmp_tail("ascii frame", 21);
    chk("ascii fcs", {wbyte(17), wbyte(18), wbyte(19), wbyte(20)}, 32'h2639F4CB);
    chk("ascii txen run", 32'(txen_cycles), 32'd21);
    chk("ascii txen rises", 32'(txen_rises), 32'd1);
    chk("ascii done count", 32'(done_cnt), 32'd1);
    chk("ascii done on last", 32'(done_pos), 32'd21);
    chk("ascii txer", 32'(txer_cnt), 32'd0);
    sel_nopad = 1'b0;

    // Padded 14-byte frame, then a back-to-back repeat with s_valid held.
    fill_pay(14, 5);
    build_expected(14, 1'b1);
    drive_frame(14, -1, 1'b1, -1);
    chk("pad timeout", 32'(timed_out), 32'd0);
    chk("pad size", 32'(wire_q.size()), 32'd72);
    cmp_tail("pad frame", 72);
    chk("pad fcs", {wbyte(71), wbyte(70), wbyte(69), wbyte(68)}, ref_fcs);
    chk("pad txen run", 32'(txen_cycles), 32'd72);
    chk("pad done on last", 32'(done_pos), 32'd72);
    measure_gap(gap, rdy_bad);
    chk("b2b gap", 32'(gap), 32'd12);
    chk("b2b ready in gap", 32'(rdy_bad), 32'd0);
    drive_frame(14, -1, 1'b0, -1);
    chk("b2b timeout", 32'(timed_out), 32'd0);
    cmp_tail("b2b frame", 64);
    chk("b2b done count", 32'(done_cnt), 32'd1);

    // Underrun after 20 of 64 bytes.
    repeat (16) @(negedge clk);
    fill_pay(64, 91);
    build_expected(64, 1'b1);
    drive_frame(64, 20, 1'b1, -1);
    chk("urun timeout", 32'(timed_out), 32'd0);
    chk("urun txen run", 32'(txen_cycles), 32'd29);
    chk("urun txen rises", 32'(txen_rises), 32'd1);
    chk("urun last byte", 32'(wbyte(28)), 32'h00);
    chk("urun byte 20", 32'(wbyte(27)), 32'(pay[19]));
    chk("urun txer", 32'(txer_cnt), 32'd1);
    chk("urun abort", 32'(abort_cnt), 32'd1);
    chk("urun done", 32'(done_cnt), 32'd0);
    measure_gap(gap, rdy_bad);
    chk("urun gap", 32'(gap), 32'd12);
    chk("urun ready in gap", 32'(rdy_bad), 32'd0);
    drive_frame(64, -1, 1'b0, -1);
    cmp_tail("urun next frame", 68);
    chk("urun next done", 32'(done_cnt), 32'd1);
    chk("urun next abort", 32'(abort_cnt), 32'd0);

    // Asynchronous reset in the middle of a payload.
    repeat (16) @(negedge clk);
    drive_frame(64, -1, 1'b0, 30);
    chk("mid reset txen", 32'(rst_txen), 32'd0);
    chk("mid reset txer", 32'(rst_txer), 32'd0);
    chk("mid reset ready", 32'(rst_rdy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fill_pay(14, 200);
    build_expected(14, 1'b1);
    drive_frame(14, -1, 1'b0, -1);
    chk("post reset latency", 32'(first_txen), 32'd1);
    chk("post reset size", 32'(wire_q.size()), 32'd72);
    cmp_tail("post reset frame", 72);

    // Maximum-size payload: no padding, single done.
    repeat (16) @(negedge clk);
    fill_pay(1514, 77);
    build_expected(1514, 1'b1);
    drive_frame(1514, -1, 1'b0, -1);
    chk("long timeout", 32'(timed_out), 32'd0);
    chk("long size", 32'(wire_q.size()), 32'd1526);
    cmp_tail("long frame", 1526);
    chk("long fcs", {wbyte(1525), wbyte(1524), wbyte(1523), wbyte(1522)}, ref_fcs);
    chk("long done count", 32'(done_cnt), 32'd1);
    chk("long txen rises", 32'(txen_rises), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
